// File: rtl/wheel_speed_est.sv
// Wheel speed estimator: samples a free-running tick counter every PERIOD cycles,
// produces a saturated per-interval delta and a 4-sample moving-average speed.
module wheel_speed_est #(
   parameter int PERIOD = 100001,
   parameter int DW     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          count,
   input  logic                 clr,
   output logic signed [DW-1:0] delta,
   output logic signed [DW-1:0] speed,
   output logic                 valid,
   output logic                 sat
);
   localparam int TW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
   localparam int SW = DW + 2;
   localparam logic [TW-1:0]        TIMER_LAST = TW'(PERIOD - 1);
   localparam logic signed [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};
   localparam logic signed [31:0]   RMAX = 32'(DMAX);
   localparam logic signed [31:0]   RMIN = 32'(DMIN);

   typedef enum logic [1:0] {EMPTY, FILL, RUN} state_t;

   state_t               state_reg;
   logic [TW-1:0]        timer_reg;
   logic [31:0]          prev_reg;
   logic [1:0]           fill_reg;
   logic signed [DW-1:0] win_reg [4];

   logic                 sample;
   logic signed [31:0]   raw;
   logic                 clip;
   logic signed [DW-1:0] delta_next;
   logic signed [SW-1:0] win_ext [3];
   logic signed [SW-1:0] sum_next;
   logic signed [DW-1:0] speed_next;

   // The three surviving window entries, widened so the 4-term sum cannot overflow.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_ext
         assign win_ext[gi] = SW'(win_reg[gi]);
      end
   endgenerate

   always_comb begin
      sample     = (timer_reg == TIMER_LAST);
      raw        = signed'(count - prev_reg);
      clip       = 1'b0;
      delta_next = raw[DW-1:0];
      if (raw > RMAX) begin
         delta_next = DMAX;
         clip       = 1'b1;
      end else if (raw < RMIN) begin
         delta_next = DMIN;
         clip       = 1'b1;
      end
      sum_next   = SW'(delta_next) + win_ext[0] + win_ext[1] + win_ext[2];
      // Dropping the two LSBs of a two's-complement sum is a floor divide by 4.
      speed_next = sum_next[SW-1:2];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= EMPTY;
         timer_reg <= '0;
         prev_reg  <= '0;
         fill_reg  <= '0;
         delta     <= '0;
         speed     <= '0;
         valid     <= 1'b0;
         sat       <= 1'b0;
         for (int i = 0; i < 4; i++) win_reg[i] <= '0;
      end else if (clr) begin
         // Clear wins over a coincident sample; that sample is simply lost.
         state_reg <= EMPTY;
         timer_reg <= '0;
         prev_reg  <= '0;
         fill_reg  <= '0;
         delta     <= '0;
         speed     <= '0;
         valid     <= 1'b0;
         sat       <= 1'b0;
         for (int i = 0; i < 4; i++) win_reg[i] <= '0;
      end else begin
         valid     <= 1'b0;
         timer_reg <= sample ? '0 : timer_reg + TW'(1);
         if (sample) begin
            prev_reg <= count;
            if (state_reg == EMPTY) begin
               state_reg <= FILL;
               fill_reg  <= '0;
            end else begin
               delta      <= delta_next;
               sat        <= sat | clip;
               win_reg[0] <= delta_next;
               for (int i = 1; i < 4; i++) win_reg[i] <= win_reg[i-1];
               if (state_reg == RUN || fill_reg == 2'd3) begin
                  state_reg <= RUN;
                  speed     <= speed_next;
                  valid     <= 1'b1;
               end else begin
                  fill_reg <= fill_reg + 2'd1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_wheel_speed_est.sv
// Randomised scoreboard bench for wheel_speed_est: a queue-based reference model
// predicts each valid strobe, an independent monitor checks what the DUT presents.
module tb_wheel_speed_est;
   localparam int PERIOD = 8;
   localparam int DW     = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 clr = 1'b0;
   logic [31:0]          count = '0;
   logic signed [DW-1:0] delta;
   logic signed [DW-1:0] speed;
   logic                 valid;
   logic                 sat;

   always #5 clk = ~clk;

   wheel_speed_est #(.PERIOD(PERIOD), .DW(DW)) dut (
      .clk   (clk),
      .rst   (rst),
      .count (count),
      .clr   (clr),
      .delta (delta),
      .speed (speed),
      .valid (valid),
      .sat   (sat)
   );

   typedef struct {
      int d;
      int s;
      int st;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model state: last sampled count, newest-first delta window.
   bit          m_have;
   logic [31:0] m_prev;
   int          m_win[$];
   int          m_delta;
   int          m_sat;
   int          m_valid;

   function automatic void chk(string name, int act, int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endfunction

   function automatic int floor4(int s);
      int q;
      q = s / 4;
      if ((s % 4 != 0) && (s < 0)) q = q - 1;
      return q;
   endfunction

   function automatic void model_clear();
      m_have  = 1'b0;
      m_prev  = '0;
      m_win.delete();
      m_delta = 0;
      m_sat   = 0;
      m_valid = 0;
   endfunction

   function automatic void model_sample(logic [31:0] v);
      int raw;
      int d;
      int sum;
      m_valid = 0;
      if (!m_have) begin
         m_have = 1'b1;
         m_prev = v;
         return;
      end
      raw    = int'(v - m_prev);
      m_prev = v;
      d      = raw;
      if (raw > 32767) begin
         d     = 32767;
         m_sat = 1;
      end else if (raw < -32768) begin
         d     = -32768;
         m_sat = 1;
      end
      m_delta = d;
      m_win.push_front(d);
      if (m_win.size() > 4) void'(m_win.pop_back());
      if (m_win.size() == 4) begin
         sum = 0;
         foreach (m_win[i]) sum += m_win[i];
         exp_q.push_back('{m_delta, floor4(sum), m_sat});
         m_valid = 1;
      end
   endfunction

   task automatic check_zero(string tag);
      chk({tag, "_delta"}, int'(delta), 0);
      chk({tag, "_speed"}, int'(speed), 0);
      chk({tag, "_valid"}, int'(valid), 0);
      chk({tag, "_sat"},   int'(sat),   0);
   endtask

   // Entered and left on a falling edge; the PERIOD-th rising edge is the sample.
   task automatic sample_with(input logic [31:0] v);
      count = v;
      repeat (PERIOD) @(posedge clk);
      model_sample(v);
      @(negedge clk);
      $display("sample count=%08h delta=%0d speed=%0d valid=%0d sat=%0d",
               v, delta, speed, valid, sat);
      chk("delta", int'(delta), m_delta);
      chk("valid", int'(valid), m_valid);
   endtask

   task automatic clr_at_sample(input logic [31:0] v);
      count = v;
      repeat (PERIOD - 1) @(posedge clk);
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      model_clear();
      @(negedge clk);
      clr = 1'b0;
      $display("clear at sample count=%08h", v);
      check_zero("clr");
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL spurious_valid: got valid=1 required no pending sample");
            end else begin
               e = exp_q.pop_front();
               $display("valid delta=%0d speed=%0d sat=%0d (exp %0d/%0d/%0d)",
                        delta, speed, sat, e.d, e.s, e.st);
               chk("mon_delta", int'(delta), e.d);
               chk("mon_speed", int'(speed), e.s);
               chk("mon_sat",   int'(sat),   e.st);
            end
         end
      end
   end

   initial begin : driver
      logic [31:0] c;
      int          step;
      int          r;
      model_clear();
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b1;

      // Constant +5 per interval starting from 100.
      for (int i = 0; i < 8; i++) sample_with(32'd100 + 32'(5 * i));

      // Clear coincident with a sample while in RUN.
      clr_at_sample(32'd200);

      // Mixed-sign window, then all-negative window for floor rounding.
      c = 32'd1000;
      sample_with(c);
      c = c + 32'd4;          sample_with(c);
      c = c + 32'd4;          sample_with(c);
      c = c - 32'd4;          sample_with(c);
      c = c - 32'd3;          sample_with(c);
      c = c - 32'd1;          sample_with(c);
      c = c - 32'd1;          sample_with(c);
      c = c - 32'd1;          sample_with(c);
      c = c - 32'd2;          sample_with(c);

      // Counter wrap across 2^32.
      sample_with(32'hFFFF_FFFE);
      sample_with(32'h0000_0001);
      chk("wrap_delta", int'(delta), 3);
      chk("wrap_sat", int'(sat), 0);

      // Saturation in both directions; sat stays set.
      c = 32'h0000_0001 + 32'd40000; sample_with(c);
      chk("sat_pos_delta", int'(delta), 32767);
      c = c - 32'd40000;             sample_with(c);
      chk("sat_neg_delta", int'(delta), -32768);
      chk("sat_sticky", int'(sat), 1);
      c = c + 32'd7;                 sample_with(c);

      // Reset pulsed in the middle of filling.
      clr_at_sample(c);
      for (int i = 0; i < 3; i++) sample_with(32'd5000 + 32'(10 * i));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_zero("rst_mid");
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) sample_with(32'd7000 - 32'(3 * i));

      // Random phase with occasional huge jumps and clears.
      clr_at_sample(32'd0);
      c = $urandom;
      sample_with(c);
      for (int i = 0; i < 48; i++) begin
         r = int'($urandom_range(0, 15));
         if (r == 0) step = int'($urandom);
         else        step = int'($urandom_range(0, 4000)) - 2000;
         c = c + 32'(step);
         if (r == 1 && i > 6) clr_at_sample(c);
         else                 sample_with(c);
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
